bcd_operand_entry: RTL and testbench
====================================

// Module: bcd_operand_entry
// PURPOSE
//  Front end of the 2-digit BCD calculator datapath.
//  Collects the two operands one BCD digit at a time from a 4-bit digit switch field and pushbuttons.
//  Presents them as in1_10/in1_1/in2_10/in2_1 plus operator, with a valid/ready handshake.
//  The add/subtract unit and the 7-seg display consume them.
//  Replaces direct switch-to-operand wiring with a sequenced, validated producer.
// PARAMETERS
//  DEBOUNCE_CYCLES  500000  stable-input cycles before a press is accepted (10 ms @ 50 MHz)
//  CNT_W            19      debounce counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES
// PORTS
//  CLOCK_50        in   1  system clock; all state updates on its rising edge
//  reset           in   1  synchronous, active-high reset
//  digit_sw        in   4  BCD digit to enter (valid 0..9)
//  op_sw           in   1  operator select: 0 = add, 1 = subtract
//  key_enter       in   1  raw pushbutton, active-high, asynchronous to CLOCK_50
//  key_clear       in   1  raw pushbutton, active-high, asynchronous to CLOCK_50
//  in1_10,in1_1    out  4  operand 1 tens/ones digit
//  in2_10,in2_1    out  4  operand 2 tens/ones digit
//  operator        out  1  latched operator
//  operands_valid  out  1  full operand set available
//  operands_ready  in   1  consumer accepts the set
//  entry_pos       out  2  slot the next digit fills: 0=in1_10, 1=in1_1, 2=in2_10, 3=in2_1
//  digit_err       out  1  1-cycle pulse: entered digit > 9, rejected
// BEHAVIOUR
//  Reset values: all digit outputs 4'd0, operator 0, operands_valid 0, entry_pos 0, digit_err 0, FSM in S_A10.
//  Button conditioning: each key passes a 2-flop synchronizer.
//   - A press produces one single-cycle internal pulse (enter_p / clear_p) on the conditioned rising edge.
//   - Holding a key never repeats.
//  FSM states and transitions:
//   - S_A10 -> S_A1 -> S_B10 -> S_B1 -> S_DONE, advancing on each accepted enter_p.
//   - entry_pos = state index in S_A10..S_B1; entry_pos = 3 in S_DONE.
//  Accept rule: on enter_p with digit_sw <= 9, the digit for the current slot registers at the next edge.
//   - Latency: 1 cycle from enter_p; the state advances in the same edge.
//  Reject rule: on enter_p with digit_sw > 9, the slot and state are unchanged and digit_err pulses for 1 cycle.
//  Operator capture: op_sw is sampled into operator on the accepted S_B1 entry only.
//  S_DONE handshake:
//   - operands_valid = 1 (registered; rises the cycle the state enters S_DONE).
//   - Digit outputs and operator are held stable while operands_valid = 1.
//   - Transfer occurs on a cycle with operands_valid & operands_ready. Next edge: operands_valid = 0, state -> S_A10.
//   - Digit values are retained after transfer so the display keeps showing them.
//   - operands_ready high while not valid: no effect.
//  Boundary conditions:
//   - enter_p in S_DONE: ignored (no write, no error).
//   - clear_p in any state: all digit outputs and operator -> 0, operands_valid -> 0, state -> S_A10.
//   - clear_p and enter_p in the same cycle: clear wins; the digit is discarded.
//   - clear_p in the same cycle as an S_DONE transfer: clear wins; the transfer still counts as completed.
//   - reset mid-entry or mid-handshake: identical to the reset values above.
//   - Starting a new entry after a transfer overwrites in1_10 first; other slots hold old values until rewritten.
// CONFIGURATION
//  DEBOUNCE_EN defined:
//   - Each synchronized key feeds a CNT_W counter that reloads on any change of the raw level.
//   - The debounced level changes only after DEBOUNCE_CYCLES consecutive stable cycles.
//   - Press-to-pulse latency = 2 + DEBOUNCE_CYCLES cycles.
//  DEBOUNCE_EN undefined:
//   - Counter logic is removed; the pulse derives from the synchronized level.
//   - Press-to-pulse latency = 3 cycles.
//   - DEBOUNCE_CYCLES and CNT_W are unused.
// STRUCTURE
//  Shared package bcd_calc_pkg holds:
//   - FSM state localparams S_A10, S_A1, S_B10, S_B1, S_DONE (3-bit encoding)
//   - BCD_MAX = 4'd9
//   - OP_ADD = 1'b0, OP_SUB = 1'b1
//  Sub-module key_conditioner (synchronizer + optional debounce + rising-edge detect).
//   - Instantiated twice: enter and clear.
//  Top level holds the FSM, digit registers and handshake.
// TESTING (bench sets DEBOUNCE_CYCLES = 4)
//  1. reset held 2 cycles -> all outputs 0, entry_pos = 0.
//  2. Enter 4,2,1,7 with op_sw = 1 ->
//     - in1 = 4|2, in2 = 1|7, operator = 1
//     - operands_valid = 1 one cycle after the 4th pulse
//     - entry_pos walks 0,1,2,3
//  3. Hold operands_ready = 0 for 10 cycles -> outputs stable, valid held.
//     Then ready = 1 for 1 cycle -> valid = 0 next cycle, state S_A10, digits retained.
//  4. Enter digit_sw = 4'hB at slot 1 -> digit_err pulses 1 cycle, in1_1 unchanged, entry_pos stays 1.
//     Then enter 5 -> in1_1 = 5.
//  5. key_clear and key_enter pressed on the same cycle at slot 2 -> all digits 0, entry_pos = 0, no digit written.
//  6. key_enter glitch shorter than 4 cycles (DEBOUNCE_EN defined) -> no pulse, no state change.
//     A 6-cycle press -> exactly one accepted digit.

Source files
------------

// File: rtl/bcd_calc_pkg.sv
// Shared constants for the 2-digit BCD calculator datapath.
//   S_A10..S_DONE : operand-entry FSM state encodings (3 bits)
//   BCD_MAX       : largest legal BCD digit
//   OP_ADD/OP_SUB : operator select encodings
package bcd_calc_pkg;
   localparam logic [2:0] S_A10  = 3'd0;
   localparam logic [2:0] S_A1   = 3'd1;
   localparam logic [2:0] S_B10  = 3'd2;
   localparam logic [2:0] S_B1   = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   localparam logic [3:0] BCD_MAX = 4'd9;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/key_conditioner.sv
// Pushbutton conditioner: 2-flop synchronizer, optional debounce, rising-edge
// detect. A press yields exactly one single-cycle pulse and holding never repeats.
// Optional feature macro: DEBOUNCE_EN.
//   With DEBOUNCE_EN    : press-to-pulse latency = 2 + DEBOUNCE_CYCLES cycles.
//   Without DEBOUNCE_EN : press-to-pulse latency = 3 cycles, parameters unused.
// Ports:
//   clk    in  system clock
//   reset  in  synchronous active-high reset
//   key    in  raw active-high button, asynchronous to clk
//   pulse  out one-cycle press pulse
module key_conditioner #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 19
) (
   input  logic clk,
   input  logic reset,
   input  logic key,
   output logic pulse
);
   logic sync1, sync2;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= key;
         sync2 <= sync1;
      end
   end

`ifdef DEBOUNCE_EN
   logic [CNT_W-1:0] cnt;
   logic             db, db_q;

   // The counter only runs while the synchronized level disagrees with the
   // debounced level. Any bounce back to the old level reloads it, so the
   // debounced level moves only after DEBOUNCE_CYCLES consecutive stable cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt  <= '0;
         db   <= 1'b0;
         db_q <= 1'b0;
      end else begin
         db_q <= db;
         if (sync2 == db) begin
            cnt <= '0;
         end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            db  <= sync2;
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign pulse = db & ~db_q;
`else
   logic sync3, pulse_q;

   // Registering the edge detect gives a fixed 3-cycle latency.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync3   <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         sync3   <= sync2;
         pulse_q <= sync2 & ~sync3;
      end
   end

   assign pulse = pulse_q;
`endif
endmodule

// File: rtl/bcd_operand_entry.sv
// Front end of the 2-digit BCD calculator. It collects two 2-digit operands one
// BCD digit at a time from digit_sw, one digit per enter press, and presents
// them with a valid/ready handshake.
// Optional feature macro: DEBOUNCE_EN (button debounce in key_conditioner).
// Ports:
//   CLOCK_50        in  system clock
//   reset           in  synchronous active-high reset
//   digit_sw[3:0]   in  digit to enter (legal 0..9)
//   op_sw           in  0 = add, 1 = subtract
//   key_enter       in  raw enter button
//   key_clear       in  raw clear button
//   in1_10,in1_1    out operand 1 tens/ones
//   in2_10,in2_1    out operand 2 tens/ones
//   operator        out latched operator
//   operands_valid  out operand set available
//   operands_ready  in  consumer accepts the set
//   entry_pos[1:0]  out slot the next digit fills
//   digit_err       out one-cycle pulse for a rejected digit greater than 9
module bcd_operand_entry
   import bcd_calc_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 19
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic [3:0] digit_sw,
   input  logic       op_sw,
   input  logic       key_enter,
   input  logic       key_clear,
   output logic [3:0] in1_10,
   output logic [3:0] in1_1,
   output logic [3:0] in2_10,
   output logic [3:0] in2_1,
   output logic       operator,
   output logic       operands_valid,
   input  logic       operands_ready,
   output logic [1:0] entry_pos,
   output logic       digit_err
);
   logic       enter_p, clear_p;
   logic [2:0] state;

   key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_key_enter (
      .clk   (CLOCK_50),
      .reset (reset),
      .key   (key_enter),
      .pulse (enter_p)
   );

   key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_key_clear (
      .clk   (CLOCK_50),
      .reset (reset),
      .key   (key_clear),
      .pulse (clear_p)
   );

   // Clear has priority over everything. In S_DONE only the handshake
   // matters and enter presses are ignored. Digits persist after a transfer
   // so the display keeps showing them.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state          <= S_A10;
         in1_10         <= 4'd0;
         in1_1          <= 4'd0;
         in2_10         <= 4'd0;
         in2_1          <= 4'd0;
         operator       <= OP_ADD;
         operands_valid <= 1'b0;
         digit_err      <= 1'b0;
      end else begin
         digit_err <= 1'b0;
         if (clear_p) begin
            state          <= S_A10;
            in1_10         <= 4'd0;
            in1_1          <= 4'd0;
            in2_10         <= 4'd0;
            in2_1          <= 4'd0;
            operator       <= OP_ADD;
            operands_valid <= 1'b0;
         end else if (state == S_DONE) begin
            if (operands_valid && operands_ready) begin
               operands_valid <= 1'b0;
               state          <= S_A10;
            end
         end else if (enter_p) begin
            if (digit_sw <= BCD_MAX) begin
               case (state)
                  S_A10:   in1_10 <= digit_sw;
                  S_A1:    in1_1  <= digit_sw;
                  S_B10:   in2_10 <= digit_sw;
                  default: in2_1  <= digit_sw;
               endcase
               if (state == S_B1) begin
                  operator       <= op_sw;
                  operands_valid <= 1'b1;
                  state          <= S_DONE;
               end else begin
                  state <= state + 3'd1;
               end
            end else begin
               digit_err <= 1'b1;
            end
         end
      end
   end

   assign entry_pos = (state == S_DONE) ? 2'd3 : state[1:0];
endmodule

// File: tb/tb_bcd_operand_entry.sv
module tb_bcd_operand_entry;
   localparam int DC = 4;
   localparam int CW = 3;

   logic       CLOCK_50 = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] digit_sw = 4'd0;
   logic       op_sw = 1'b0;
   logic       key_enter = 1'b0;
   logic       key_clear = 1'b0;
   logic       operands_ready = 1'b0;
   logic [3:0] in1_10, in1_1, in2_10, in2_1;
   logic       operator, operands_valid, digit_err;
   logic [1:0] entry_pos;

   always #5 CLOCK_50 = ~CLOCK_50;

   bcd_operand_entry #(.DEBOUNCE_CYCLES(DC), .CNT_W(CW)) dut (
      .CLOCK_50       (CLOCK_50),
      .reset          (reset),
      .digit_sw       (digit_sw),
      .op_sw          (op_sw),
      .key_enter      (key_enter),
      .key_clear      (key_clear),
      .in1_10         (in1_10),
      .in1_1          (in1_1),
      .in2_10         (in2_10),
      .in2_1          (in2_1),
      .operator       (operator),
      .operands_valid (operands_valid),
      .operands_ready (operands_ready),
      .entry_pos      (entry_pos),
      .digit_err      (digit_err)
   );

   typedef struct packed {
      logic [3:0] a10, a1, b10, b1;
      logic       op;
   } opset_t;

   opset_t     sb_q[$];
   int         errors = 0;
   int         checks = 0;
   int         err_seen = 0;
   int         err_exp = 0;
   // reference model: four slots, number of digits taken (4 = set complete)
   int         m_slot[4];
   int         m_pos = 0;
   int         m_op = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge CLOCK_50);
      #1;
   endtask

   task automatic model_clear();
      if (m_pos == 4) void'(sb_q.pop_back());
      for (int i = 0; i < 4; i++) m_slot[i] = 0;
      m_op  = 0;
      m_pos = 0;
   endtask

   task automatic check_state(input string tag);
      chk({tag, ".entry_pos"}, int'(entry_pos), (m_pos > 3) ? 3 : m_pos);
      chk({tag, ".in1_10"}, int'(in1_10), m_slot[0]);
      chk({tag, ".in1_1"}, int'(in1_1), m_slot[1]);
      chk({tag, ".in2_10"}, int'(in2_10), m_slot[2]);
      chk({tag, ".in2_1"}, int'(in2_1), m_slot[3]);
      chk({tag, ".operator"}, int'(operator), m_op);
      chk({tag, ".valid"}, int'(operands_valid), (m_pos == 4) ? 1 : 0);
   endtask

   task automatic model_enter(input int d, input int op);
      if (m_pos < 4) begin
         if (d <= 9) begin
            m_slot[m_pos] = d;
            if (m_pos == 3) begin
               m_op = op;
               sb_q.push_back(opset_t'{4'(m_slot[0]), 4'(m_slot[1]), 4'(m_slot[2]),
                                       4'(m_slot[3]), 1'(op)});
            end
            m_pos++;
         end else begin
            err_exp++;
         end
      end
   endtask

   // press/release long enough for either conditioner build
   task automatic press(input int d, input int op, input bit ent, input bit clr, input int hold);
      digit_sw  = 4'(d);
      op_sw     = 1'(op);
      key_enter = ent;
      key_clear = clr;
      step(hold);
      key_enter = 1'b0;
      key_clear = 1'b0;
      step(10);
      if (clr) model_clear();
      else if (ent) model_enter(d, op);
   endtask

   task automatic transfer(input int hold);
      chk("xfer.valid_before", int'(operands_valid), 1);
      for (int i = 0; i < hold; i++) begin
         step(1);
         check_state("hold");
      end
      operands_ready = 1'b1;
      step(1);
      operands_ready = 1'b0;
      step(1);
      if (m_pos == 4) m_pos = 0;
      check_state("post_xfer");
   endtask

   // scoreboard monitor: each accepted handshake must match the oldest expected set
   always @(negedge CLOCK_50) begin
      if (!reset && digit_err) err_seen++;
      if (!reset && operands_valid && operands_ready) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: got transfer expected none");
         end else begin
            opset_t e;
            e = sb_q.pop_front();
            chk("sb.in1_10", int'(in1_10), int'(e.a10));
            chk("sb.in1_1", int'(in1_1), int'(e.a1));
            chk("sb.in2_10", int'(in2_10), int'(e.b10));
            chk("sb.in2_1", int'(in2_1), int'(e.b1));
            chk("sb.operator", int'(operator), int'(e.op));
         end
      end
   end

   initial begin
      int e0;
      for (int i = 0; i < 4; i++) m_slot[i] = 0;
      reset = 1'b1;
      step(2);
      reset = 1'b0;
      step(1);
      check_state("reset");
      chk("reset.digit_err", int'(digit_err), 0);

      // 4,2,1,7 subtract, entry_pos walking 0..3
      press(4, 0, 1, 0, 8); chk("walk.pos1", int'(entry_pos), 1);
      press(2, 0, 1, 0, 8); chk("walk.pos2", int'(entry_pos), 2);
      press(1, 0, 1, 0, 8); chk("walk.pos3", int'(entry_pos), 3);
      press(7, 1, 1, 0, 8);
      check_state("walk_done");
      press(3, 0, 1, 0, 8);            // ignored in S_DONE
      check_state("enter_in_done");
      transfer(10);

      // rejected digit at slot 1, then a good one
      press(6, 0, 1, 0, 8);
      e0 = err_seen;
      press(11, 0, 1, 0, 8);
      chk("reject.err_pulses", err_seen - e0, 1);
      check_state("reject");
      press(5, 0, 1, 0, 8);
      check_state("after_reject");

      // clear and enter together at slot 2: clear wins
      press(8, 1, 1, 1, 8);
      check_state("clear_enter");

      // ready while not valid has no effect
      operands_ready = 1'b1;
      step(3);
      operands_ready = 1'b0;
      step(1);
      check_state("ready_idle");

      // reset mid-entry
      press(9, 0, 1, 0, 8);
      reset = 1'b1;
      step(2);
      reset = 1'b0;
      step(1);
      model_clear();
      check_state("reset_mid");

`ifdef DEBOUNCE_EN
      key_enter = 1'b1;
      digit_sw  = 4'd3;
      step(3);
      key_enter = 1'b0;
      step(12);
      check_state("glitch");
      press(3, 0, 1, 0, 6);
      check_state("six_cycle_press");
`endif

      for (int it = 0; it < 70; it++) begin
         int r;
         r = int'($urandom_range(0, 9));
         if (m_pos == 4 && r < 5) transfer(int'($urandom_range(0, 3)));
         else if (r < 7) press(($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 15))
                                                           : int'($urandom_range(0, 9)),
                               int'($urandom_range(0, 1)), 1, 0, 8);
         else if (r == 7) press(0, 0, 0, 1, 8);
         else if (r == 8) press(int'($urandom_range(0, 9)), 1, 1, 1, 8);
         else press(int'($urandom_range(0, 15)), int'($urandom_range(0, 1)), 1, 0, 8);
         check_state("rand");
      end
      if (m_pos == 4) transfer(1);

      step(2);
      chk("sb.drained", sb_q.size(), 0);
      chk("digit_err.count", err_seen, err_exp);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
